// File: rtl/xmt_d_pkg.sv
// xmt_d_pkg: shared definitions for the xmt_d serial transmitter.
//   DATA_W          width of one transmitted byte
//   CNT_W           width of the bit-period counter (CLK_DIV up to 255)
//   CLK_DIV_DEFAULT default number of clocks per bit period
//   state_t         transmitter states; PARITY exists only when the
//                   optional parity bit is compiled in (macro XMT_D_PARITY_EN)
package xmt_d_pkg;

  localparam int DATA_W          = 8;
  localparam int CNT_W           = 8;
  localparam int CLK_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef XMT_D_PARITY_EN
    PARITY = 2'd2,
`endif
    GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/xmt_d_baud.sv
// xmt_d_baud: bit-period counter for the xmt_d transmitter.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   active       a bit period is in progress (DATA, PARITY or GAP)
//   strobe_en    the current bit period carries a strobe (DATA or PARITY)
//   period_end   combinational: last cycle of the current bit period
//   near_end     combinational: second-to-last cycle of the bit period
//   strobe       registered: high in the cycle the counter equals CLK_DIV/2
module xmt_d_baud
  import xmt_d_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic strobe_en,
  output logic period_end,
  output logic near_end,
  output logic strobe
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] NEAR       = CNT_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] PRE_STROBE = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0] cnt;

  assign period_end = active && (cnt == LAST);
  assign near_end   = active && (cnt == NEAR);

  // The strobe is registered, so it is raised one cycle early: when the
  // counter sits at CLK_DIV/2-1 it will read CLK_DIV/2 next cycle. That
  // point is never a period end, so the state (and strobe_en) is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      if (!active || cnt == LAST)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      strobe <= strobe_en && (cnt == PRE_STROBE);
    end
  end

endmodule

// File: rtl/xmt_d.sv
// xmt_d: byte-wide serial transmitter, LSB first, with frame and strobe lines.
// Optional feature: define XMT_D_PARITY_EN to append a parity bit period.
// Parameters:
//   CLK_DIV  clocks per bit period (2..255)
//   PAR_ODD  parity sense, 0 = even, 1 = odd (only with XMT_D_PARITY_EN)
// Ports:
//   xmt_d_clk, xmt_d_rst_n   clock and asynchronous active-low reset
//   xmt_d_in_data/valid      byte to send and its qualifier
//   xmt_d_in_ready           high while idle and able to take a byte
//   xmt_d_out1               serial data, LSB first
//   xmt_d_out2               frame line, high during every frame bit period
//   xmt_d_out3               one-cycle strobe in the middle of each bit period
//   xmt_d_done               one-cycle pulse in the last cycle of a frame
// All outputs come straight from flops; they are loaded from next-state values.
module xmt_d
  import xmt_d_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int PAR_ODD = 0
) (
  input  logic              xmt_d_clk,
  input  logic              xmt_d_rst_n,
  input  logic [DATA_W-1:0] xmt_d_in_data,
  input  logic              xmt_d_in_valid,
  output logic              xmt_d_in_ready,
  output logic              xmt_d_out1,
  output logic              xmt_d_out2,
  output logic              xmt_d_out3,
  output logic              xmt_d_done
);

  if (CLK_DIV < 2 || CLK_DIV > 255 || PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_params
    $error("xmt_d: CLK_DIV must be 2..255 and PAR_ODD must be 0 or 1");
  end

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic              accept, in_frame, in_frame_next, last_bit;
  logic              out1_next, period_end, near_end;

`ifdef XMT_D_PARITY_EN
  logic par, par_next;
  assign in_frame      = (state == DATA) || (state == PARITY);
  assign in_frame_next = (state_next == DATA) || (state_next == PARITY);
  assign last_bit      = (state == PARITY);
`else
  assign in_frame      = (state == DATA);
  assign in_frame_next = (state_next == DATA);
  assign last_bit      = (state == DATA) && (bit_idx == 3'd7);
`endif

  assign accept = xmt_d_in_valid && xmt_d_in_ready;

  xmt_d_baud #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk       (xmt_d_clk),
    .rst_n     (xmt_d_rst_n),
    .active    (state != IDLE),
    .strobe_en (in_frame),
    .period_end(period_end),
    .near_end  (near_end),
    .strobe    (xmt_d_out3)
  );

  // Next-state logic. Input data is only looked at in IDLE with a handshake,
  // so it is ignored for the whole frame and gap.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
`ifdef XMT_D_PARITY_EN
    par_next     = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = DATA;
          shreg_next   = xmt_d_in_data;
          bit_idx_next = '0;
`ifdef XMT_D_PARITY_EN
          par_next     = (^xmt_d_in_data) ^ 1'(PAR_ODD);
`endif
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_idx == 3'd7) begin
`ifdef XMT_D_PARITY_EN
            state_next = PARITY;
`else
            state_next = GAP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
          end
        end
      end
`ifdef XMT_D_PARITY_EN
      PARITY: begin
        if (period_end) state_next = GAP;
      end
`endif
      GAP: begin
        if (period_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    out1_next = 1'b0;
    if (state_next == DATA)
      out1_next = shreg_next[0];
`ifdef XMT_D_PARITY_EN
    else if (state_next == PARITY)
      out1_next = par_next;
`endif
  end

  // State and output registers. done is loaded in the second-to-last cycle
  // of the final bit period so that it is high during the last one.
  always_ff @(posedge xmt_d_clk or negedge xmt_d_rst_n) begin
    if (!xmt_d_rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_idx        <= '0;
`ifdef XMT_D_PARITY_EN
      par            <= 1'b0;
`endif
      xmt_d_in_ready <= 1'b0;
      xmt_d_out1     <= 1'b0;
      xmt_d_out2     <= 1'b0;
      xmt_d_done     <= 1'b0;
    end else begin
      state          <= state_next;
      shreg          <= shreg_next;
      bit_idx        <= bit_idx_next;
`ifdef XMT_D_PARITY_EN
      par            <= par_next;
`endif
      xmt_d_in_ready <= (state_next == IDLE);
      xmt_d_out1     <= out1_next;
      xmt_d_out2     <= in_frame_next;
      xmt_d_done     <= near_end && last_bit;
    end
  end

endmodule

// File: doc/xmt_d.md
XMT_D -- requirements
Module: xmt_d

Interface
REQ-001 Parameter CLK_DIV, default 4, clocks per bit period; legal range 2..255.
REQ-002 Parameter PAR_ODD, default 0, parity sense: 0 = even, 1 = odd; used only with XMT_D_PARITY_EN.
REQ-003 xmt_d_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 xmt_d_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 xmt_d_in_data  input  8  byte to transmit.
REQ-006 xmt_d_in_valid  input  1  xmt_d_in_data is valid.
REQ-007 xmt_d_in_ready  output  1  block can accept a byte.
REQ-008 xmt_d_out1  output  1  serial data line, LSB first.
REQ-009 xmt_d_out2  output  1  frame line, high for every bit period of a frame.
REQ-010 xmt_d_out3  output  1  bit strobe, one-cycle pulse per bit period for the receiving end.
REQ-011 xmt_d_done  output  1  one-cycle pulse when the last bit period of a frame completes.

Function
REQ-012 States: IDLE, DATA, PARITY (only with XMT_D_PARITY_EN), GAP.
REQ-013 In IDLE, xmt_d_in_ready SHALL be 1; in every other state it SHALL be 0; all outputs are registered.
REQ-014 A byte is accepted on a clock edge with xmt_d_in_valid=1 and xmt_d_in_ready=1; the byte is latched into a shift register, and IDLE->DATA.
REQ-015 xmt_d_in_data and xmt_d_in_valid SHALL be ignored whenever xmt_d_in_ready=0.
REQ-016 xmt_d_out2=1 and xmt_d_out1=bit0 from the cycle after acceptance (latency 1 clock).
REQ-017 Bit-period counter runs 0..CLK_DIV-1 and restarts at 0 at the start of each bit period; xmt_d_out1 is stable for the whole period.
REQ-018 xmt_d_out3=1 exactly in the cycle where the counter equals CLK_DIV/2 (integer division); otherwise 0.
REQ-019 DATA lasts 8 bit periods, bits 0..7 in order; then PARITY if compiled in, else GAP.
REQ-020 GAP lasts 1 bit period with xmt_d_out2=0, xmt_d_out1=0, xmt_d_out3=0; then IDLE.
REQ-021 xmt_d_done=1 for exactly the last cycle of the last DATA/PARITY bit period.
REQ-022 Back-to-back: acceptance in the first IDLE cycle after GAP gives frame spacing of exactly CLK_DIV+1 clocks with xmt_d_out2=0.
REQ-023 Outside a frame, xmt_d_out1=0 and xmt_d_out3=0.

Reset
REQ-024 Assertion of xmt_d_rst_n=0 SHALL immediately force state IDLE, counters 0, shift register 0, xmt_d_out1/2/3=0, xmt_d_done=0, and xmt_d_in_ready=0 while reset is held.
REQ-025 Reset mid-frame abandons the frame; no partial frame resumes after release.
REQ-026 xmt_d_in_ready SHALL go to 1 on the first clock edge after deassertion.

Configuration
REQ-027 Macro XMT_D_PARITY_EN defined: PARITY state adds a 9th bit period carrying XOR(data) XOR PAR_ODD, with xmt_d_out2=1 and xmt_d_out3 pulsing.
REQ-028 Macro XMT_D_PARITY_EN undefined: no PARITY state or logic; frame = 8 bit periods; PAR_ODD is unused.

Structure
REQ-029 Package xmt_d_pkg SHALL hold the state enum typedef, the data width constant (8), and the CLK_DIV default.
REQ-030 Sub-module xmt_d_baud SHALL implement the bit-period counter, producing the strobe and end-of-period pulse.

Verification
REQ-031 Reset then idle: xmt_d_in_ready=1 and all other outputs=0 for 20 clocks.
REQ-032 CLK_DIV=4, send 0xA5 without parity: xmt_d_out1 sequence 1,0,1,0,0,1,0,1, each held 4 clocks; xmt_d_out2 high for 32 clocks; 8 strobes at counter=2; xmt_d_done at clock 32.
REQ-033 XMT_D_PARITY_EN, PAR_ODD=0, send 0xA5 -> 9th bit=0; send 0x01 -> 9th bit=1; xmt_d_out2 high for 36 clocks.
REQ-034 Send 0x3C, then 0xC3 with valid held high: second frame starts 5 clocks after the first ends, and the second byte is sampled only at acceptance.
REQ-035 Assert reset during bit 4 of 0xFF: outputs reach 0 without a clock edge; after release, no residual bits and xmt_d_in_ready=1 on the first edge.
REQ-036 Toggle xmt_d_in_data during a frame: the transmitted byte is unchanged.
